// File: rtl/wb_stage.sv
// wb_stage: write-back register stage with load-wait stall FSM; WB_PERF_CNT_EN adds retire/stall counters
module wb_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 4,
  parameter int LOAD_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      WB_EN_in,
  input  logic                      MEM_R_EN_in,
  input  logic [REG_FILE_DEPTH-1:0] Dest_in,
  input  logic [WORD_WIDTH-1:0]     ALU_Res_in,
  input  logic [WORD_WIDTH-1:0]     Mem_Data_in,
  input  logic                      Mem_ready,
  output logic                      WB_EN,
  output logic [REG_FILE_DEPTH-1:0] WB_Dest,
  output logic [WORD_WIDTH-1:0]     WB_Value,
  output logic                      Stall_out,
  output logic                      Load_Err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]               Retire_Cnt,
  output logic [31:0]               Stall_Cnt
`endif
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  localparam logic [7:0] TMO = 8'(LOAD_TIMEOUT);
  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      lat_en_q, lat_en_d;
  logic [REG_FILE_DEPTH-1:0] lat_dest_q, lat_dest_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_FILE_DEPTH-1:0] wb_dest_q, wb_dest_d;
  logic [WORD_WIDTH-1:0]     wb_val_q, wb_val_d;
  logic                      err_q, err_d;
  // stall while a load is outstanding; at the timeout count the stage releases the pipeline
  assign Stall_out = !rst && (state_q == IDLE ? MEM_R_EN_in && !Mem_ready
                                              : !Mem_ready && cnt_q != TMO);
  assign WB_EN    = wb_en_q;
  assign WB_Dest  = wb_dest_q;
  assign WB_Value = wb_val_q;
  assign Load_Err = err_q;
  // next-state: capture MEM results in IDLE, park a pending load in LOAD_WAIT until data or timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_en_d   = lat_en_q;
    lat_dest_d = lat_dest_q;
    wb_en_d    = wb_en_q;
    wb_dest_d  = wb_dest_q;
    wb_val_d   = wb_val_q;
    err_d      = err_q;
    if (state_q == IDLE) begin
      if (MEM_R_EN_in && !Mem_ready) begin
        lat_en_d   = WB_EN_in;
        lat_dest_d = Dest_in;
        wb_en_d    = 1'b0;
        cnt_d      = '0;
        state_d    = LOAD_WAIT;
      end else begin
        wb_en_d   = WB_EN_in;
        wb_dest_d = Dest_in;
        wb_val_d  = MEM_R_EN_in ? Mem_Data_in : ALU_Res_in;
      end
    end else if (Mem_ready) begin
      wb_en_d   = lat_en_q;
      wb_dest_d = lat_dest_q;
      wb_val_d  = Mem_Data_in;
      state_d   = IDLE;
    end else if (cnt_q == TMO) begin
      err_d   = 1'b1;
      wb_en_d = 1'b0;
      state_d = IDLE;
    end else begin
      cnt_d   = cnt_q + 8'd1;
      wb_en_d = 1'b0;
    end
  end
  // state and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_en_q   <= 1'b0;
      lat_dest_q <= '0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_val_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_en_q   <= lat_en_d;
      lat_dest_q <= lat_dest_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_val_q   <= wb_val_d;
      err_q      <= err_d;
    end
  end
`ifdef WB_PERF_CNT_EN
  // free-running retire and stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      Retire_Cnt <= '0;
      Stall_Cnt  <= '0;
    end else begin
      Retire_Cnt <= Retire_Cnt + 32'(wb_en_q);
      Stall_Cnt  <= Stall_Cnt + 32'(Stall_out);
    end
  end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven and randomized transaction-level checks of wb_stage
module tb_wb_stage;
  localparam int TMO = 8;
  logic        clk = 1'b0;
  logic        rst, we, rd, rdy;
  logic [3:0]  dest;
  logic [31:0] alu, mdat;
  logic        wb_en, stall, err;
  logic [3:0]  wb_dest;
  logic [31:0] wb_val;
  int          checks = 0;
  int          fails = 0;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  wb_stage #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4), .LOAD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .WB_EN_in(we), .MEM_R_EN_in(rd), .Dest_in(dest),
    .ALU_Res_in(alu), .Mem_Data_in(mdat), .Mem_ready(rdy),
    .WB_EN(wb_en), .WB_Dest(wb_dest), .WB_Value(wb_val),
    .Stall_out(stall), .Load_Err(err)
`ifdef WB_PERF_CNT_EN
    , .Retire_Cnt(retire_cnt), .Stall_Cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // presents one MEM instruction, holds it while stalled; Mem_ready rises lat cycles after presentation
  task automatic run(input logic w, input logic r, input logic [3:0] d, input logic [31:0] a,
                     input logic [31:0] m, input int lat, output int stalls);
    logic s;
    int   k;
    stalls = 0;
    k = 0;
    s = 1'b1;
    while (s && k < 400) begin
      @(negedge clk);
      rst = 1'b0; we = w; rd = r; dest = d; alu = a;
      rdy  = r ? (k == lat) : 1'($urandom);
      mdat = (r && rdy) ? m : $urandom;
      #1 s = stall;
      @(posedge clk);
      #1;
      if (s) begin
        stalls++;
        chk("en_during_stall", wb_en, 0);
      end
      k++;
    end
    if (s) chk("stall_bound", 1, 0);
  endtask

  typedef struct {
    logic w, r; logic [3:0] d; logic [31:0] a, m; int lat;
    logic x_en; logic chk_dv; logic [3:0] x_dest; logic [31:0] x_val; int x_stall; logic x_err;
  } vec_t;

  vec_t tbl[9];
  int   st;
  logic err_exp;

  initial begin
    tbl[0] = '{1, 0,  3, 32'h0000_00A5, 32'h0,         0, 1, 1,  3, 32'h0000_00A5, 0, 0};
    tbl[1] = '{1, 1,  7, 32'h0000_1111, 32'hDEAD_BEEF, 0, 1, 1,  7, 32'hDEAD_BEEF, 0, 0};
    tbl[2] = '{1, 1,  7, 32'h0000_2222, 32'hCAFE_F00D, 4, 1, 1,  7, 32'hCAFE_F00D, 4, 0};
    tbl[3] = '{0, 1,  5, 32'h0000_0003, 32'h1234_5678, 2, 0, 1,  5, 32'h1234_5678, 2, 0};
    tbl[4] = '{1, 0, 15, 32'hFFFF_FFFF, 32'h0,         0, 1, 1, 15, 32'hFFFF_FFFF, 0, 0};
    tbl[5] = '{1, 1,  9, 32'h0000_0004, 32'hABCD_0001, 9, 1, 1,  9, 32'hABCD_0001, 9, 0};
    tbl[6] = '{1, 1,  2, 32'h0000_0005, 32'h0000_0006, 20, 0, 0, 0, 32'h0,         9, 1};
    tbl[7] = '{1, 0,  4, 32'h0000_0077, 32'h0,         0, 1, 1,  4, 32'h0000_0077, 0, 1};
    tbl[8] = '{0, 0,  6, 32'h0000_0088, 32'h0,         0, 0, 1,  6, 32'h0000_0088, 0, 1};

    rst = 1'b1; we = 1'b1; rd = 1'b1; rdy = 1'b0; dest = 4'd9; alu = 32'h55; mdat = 32'h66;
    repeat (2) begin
      @(negedge clk);
      #1 chk("stall_in_reset", stall, 0);
      @(posedge clk);
    end
    #1;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_value", wb_val, 0);
    chk("rst_load_err", err, 0);

    for (int i = 0; i < 9; i++) begin
      run(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].lat, st);
      chk($sformatf("vec%0d_stalls", i), st, tbl[i].x_stall);
      chk($sformatf("vec%0d_wb_en", i), wb_en, tbl[i].x_en);
      if (tbl[i].chk_dv) begin
        chk($sformatf("vec%0d_wb_dest", i), wb_dest, tbl[i].x_dest);
        chk($sformatf("vec%0d_wb_value", i), wb_val, tbl[i].x_val);
      end
      chk($sformatf("vec%0d_load_err", i), err, tbl[i].x_err);
`ifdef WB_PERF_CNT_EN
      if (i == 2) chk("stall_cnt_delayed_load", stall_cnt, 4);
`endif
    end

    @(negedge clk);
    we = 1'b1; rd = 1'b1; dest = 4'd11; rdy = 1'b0;
    #1 chk("midwait_stall_idle", stall, 1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      #1 chk("midwait_stall_wait", stall, 1);
    end
    rst = 1'b1;
    #1 chk("midwait_stall_masked", stall, 0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; rd = 1'b0; rdy = 1'b1; mdat = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    chk("midwait_no_write", wb_en, 0);
    chk("midwait_load_err", err, 0);

    err_exp = 1'b0;
    for (int n = 0; n < 150; n++) begin
      logic w, r; logic [3:0] d; logic [31:0] a, m; int lat;
      logic ok;
      w = 1'($urandom); r = 1'($urandom); d = 4'($urandom);
      a = $urandom; m = $urandom; lat = $urandom_range(0, TMO + 4);
      run(w, r, d, a, m, lat, st);
      ok = !r || lat <= TMO + 1;
      if (!ok) err_exp = 1'b1;
      chk("rnd_stalls", st, ok ? (r ? lat : 0) : TMO + 1);
      chk("rnd_wb_en", wb_en, ok ? w : 1'b0);
      if (ok) begin
        chk("rnd_wb_dest", wb_dest, d);
        chk("rnd_wb_value", wb_val, r ? m : a);
      end
      chk("rnd_load_err", err, err_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 32-bit ARM pipeline. It closes the loop back into the decode stage's register file by registering results leaving the memory stage and selecting between ALU result and load data. It drives the register-file write port (`WB_EN`, `WB_Dest`, `WB_Value`). A small load-wait FSM stalls the pipeline until the data SRAM returns read data, with a timeout to avoid deadlock.

## Interface
Parameters:
- `WORD_WIDTH`, 32, data width; matches `` `WORD_WIDTH ``.
- `REG_FILE_DEPTH`, 4, register index width; matches `` `REG_FILE_DEPTH ``.
- `LOAD_TIMEOUT`, 255, maximum `LOAD_WAIT` cycles before abort; range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `WB_EN_in`  in  1  instruction in MEM writes a register.
- `MEM_R_EN_in`  in  1  instruction in MEM is a load.
- `Dest_in`  in  REG_FILE_DEPTH  destination register of the MEM instruction.
- `ALU_Res_in`  in  WORD_WIDTH  ALU result / address from MEM.
- `Mem_Data_in`  in  WORD_WIDTH  SRAM read data; valid only while `Mem_ready`=1.
- `Mem_ready`  in  1  SRAM read data valid this cycle.
- `WB_EN`  out  1  register-file write enable.
- `WB_Dest`  out  REG_FILE_DEPTH  register-file write index.
- `WB_Value`  out  WORD_WIDTH  register-file write data.
- `Stall_out`  out  1  freeze request to IF/ID/EX/MEM; combinational.
- `Load_Err`  out  1  sticky; a load timed out.

## Operation
- FSM states:
  - `IDLE`: capture MEM inputs every cycle.
  - `LOAD_WAIT`: hold the captured load until `Mem_ready`.
- In `IDLE`, on each edge:
  - **Non-load** (`MEM_R_EN_in`=0): `WB_EN`<=`WB_EN_in`, `WB_Dest`<=`Dest_in`, `WB_Value`<=`ALU_Res_in`.
  - **Load, data ready** (`MEM_R_EN_in`=1, `Mem_ready`=1): `WB_Value`<=`Mem_Data_in`, `WB_EN`<=`WB_EN_in`, `WB_Dest`<=`Dest_in`.
  - **Load, data not ready** (`MEM_R_EN_in`=1, `Mem_ready`=0): latch `Dest_in` and `WB_EN_in` internally, `WB_EN`<=0, clear the timeout counter, go to `LOAD_WAIT`.
- In `LOAD_WAIT`:
  - `Mem_ready`=1: `WB_EN`<=latched enable, `WB_Dest`<=latched dest, `WB_Value`<=`Mem_Data_in`, go to `IDLE`.
  - `Mem_ready`=0: counter increments and `WB_EN`<=0.
  - Counter reaches `LOAD_TIMEOUT` with `Mem_ready`=0: `Load_Err`<=1, `WB_EN`<=0 (the load is dropped), go to `IDLE`.
- `Stall_out` = (`IDLE` & `MEM_R_EN_in` & ~`Mem_ready`) | (`LOAD_WAIT` & ~`Mem_ready` & counter≠`LOAD_TIMEOUT`).
- Upstream holds the MEM inputs stable while `Stall_out`=1; inputs are ignored in `LOAD_WAIT`.
- A load with `WB_EN_in`=0 still waits for `Mem_ready`, but writes nothing.
- Any `WB_Dest`, including 4'd15, is passed through unchanged; there is no special handling of PC.
- `Load_Err` clears only on `rst`.

## Timing
- Reset values: `WB_EN`=0, `WB_Dest`=0, `WB_Value`=0, `Load_Err`=0, state=`IDLE`, counter=0. `Stall_out` evaluates to 0 from `IDLE` when `MEM_R_EN_in`=0.
- Latency, non-load or ready load: 1 cycle from MEM input to `WB_*` output.
- Latency, delayed load: write appears 1 cycle after the cycle in which `Mem_ready`=1.
- `WB_*` outputs are registered and stable for one full cycle; the register file samples them on the next rising edge.
- `rst` asserted in `LOAD_WAIT`: the pending load is discarded, the FSM enters `IDLE`, and `Stall_out` drops in the same cycle only if `rst` also masks it. `Stall_out` is forced to 0 while `rst`=1.
- `Mem_ready` arriving exactly when the counter equals `LOAD_TIMEOUT`: the data wins; write it and do not set `Load_Err`.

## Configuration
- `WB_PERF_CNT_EN` defined: two additional 32-bit outputs, each wrapping at 2^32 and reset to 0.
  - `Retire_Cnt`: increments on each cycle with `WB_EN`=1.
  - `Stall_Cnt`: increments on each cycle with `Stall_out`=1.
- `WB_PERF_CNT_EN` undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `MEM_R_EN_in`=1 and `Mem_ready`=0 → all outputs 0, `Stall_out`=0.
- **ALU write:** `WB_EN_in`=1, `Dest_in`=3, `ALU_Res_in`=0x0000_00A5, `MEM_R_EN_in`=0 → next cycle `WB_EN`=1, `WB_Dest`=3, `WB_Value`=0xA5.
- **Ready load:** `MEM_R_EN_in`=1, `Mem_ready`=1, `Mem_Data_in`=0xDEAD_BEEF, `Dest_in`=7 → next cycle write of r7=0xDEADBEEF, no stall.
- **Delayed load:** `Mem_ready` rises 4 cycles after the load is presented → `Stall_out`=1 for 4 cycles, `WB_EN`=0 during the wait, then r7 is written with the data. With `WB_PERF_CNT_EN`, `Stall_Cnt`=4.
- **Timeout:** `LOAD_TIMEOUT`=8, `Mem_ready` held 0 → `Load_Err`=1 after the timeout, no write, FSM back in `IDLE`, `Stall_out` released. A subsequent ALU op writes normally.
- **Reset mid-wait:** assert `rst` during `LOAD_WAIT`, then `Mem_ready`=1 → no write occurs, `Load_Err`=0.
